// File: rtl/counter_threshold_monitor_if.sv
// Event readout port of the threshold monitor.
// Valid/ready handshake carrying channel, captured count and timestamp.
interface counter_threshold_monitor_if #(
  parameter int CNT_W = 64
);
  logic             Evt_Valid;
  logic             Evt_Ready;
  logic             Evt_Ch;
  logic [CNT_W-1:0] Evt_Value;
  logic [31:0]      Evt_Time;

  modport master (
    output Evt_Valid,
    output Evt_Ch,
    output Evt_Value,
    output Evt_Time,
    input  Evt_Ready
  );

  modport slave (
    input  Evt_Valid,
    input  Evt_Ch,
    input  Evt_Value,
    input  Evt_Time,
    output Evt_Ready
  );
endinterface

// File: rtl/counter_threshold_monitor.sv
// Threshold-crossing monitor for two counter channels with an event FIFO.
// Define MONITOR_TIMESTAMP_EN to stamp events with a 32-bit cycle count.
module counter_threshold_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 64
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [CNT_W-1:0]           Count0,
  input  logic [CNT_W-1:0]           Count1,
  input  logic                       Cfg_We,
  input  logic                       Cfg_Sel,
  input  logic [CNT_W-1:0]           Cfg_Data,
  counter_threshold_monitor_if.master Evt,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Level,
  output logic                       Ovf,
  input  logic                       Ovf_Clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [CNT_W-1:0] cnt  [2];
  logic [CNT_W-1:0] thr  [2];
  logic [CNT_W-1:0] prev [2];
  logic [CNT_W-1:0] pval [2];
  logic [1:0]       armed;
  logic [1:0]       pend;
  logic [1:0]       hit;
  logic [1:0]       rearm;
  logic [1:0]       wr;
  logic [1:0]       clr;
  logic             pop;
  logic             push;
  logic             push_ch;
  logic             ovf_set;

  assign cnt[0] = Count0;
  assign cnt[1] = Count1;
  assign wr     = Cfg_We ? (Cfg_Sel ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    hit   = '0;
    rearm = '0;
    for (int c = 0; c < 2; c++) begin
      hit[c]   = armed[c] && (cnt[c] >= thr[c]);
      rearm[c] = (cnt[c] < prev[c]) || wr[c];
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  assign pop     = Evt.Evt_Valid && Evt.Evt_Ready;
  assign push    = (|pend)
                && ((Fifo_Level != LW'(FIFO_DEPTH)) || pop);
  assign push_ch = ~pend[0];
  assign clr     = push ? (pend[0] ? 2'b01 : 2'b10) : 2'b00;
  assign ovf_set = |(hit & pend & ~clr);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      armed <= '1;
      pend  <= '0;
      for (int c = 0; c < 2; c++) begin
        thr[c]  <= '1;
        prev[c] <= '0;
        pval[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        prev[c] <= cnt[c];
        if (wr[c])
          thr[c] <= Cfg_Data;
        if (hit[c]) begin
          armed[c] <= 1'b0;
          pend[c]  <= 1'b1;
          pval[c]  <= cnt[c];
        end else begin
          if (rearm[c])
            armed[c] <= 1'b1;
          if (clr[c])
            pend[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      Ovf <= 1'b0;
    else if (ovf_set)
      Ovf <= 1'b1;
    else if (Ovf_Clr)
      Ovf <= 1'b0;
  end

  logic             mem_ch  [FIFO_DEPTH];
  logic [CNT_W-1:0] mem_val [FIFO_DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_n;
  logic [LW-1:0]    level_n;
  logic             bypass;
  logic             head_ld;
  logic             head_ch;
  logic [CNT_W-1:0] head_val;

  assign rptr_n  = pop ? rptr + AW'(1) : rptr;
  assign level_n = Fifo_Level + LW'(push) - LW'(pop);
  // Entry pushed into an otherwise empty FIFO goes straight to the head
  assign bypass  = push && (Fifo_Level == LW'(pop));
  assign head_ld = level_n != '0;

  always_ff @(posedge Clk) begin
    if (push) begin
      mem_ch[wptr]  <= push_ch;
      mem_val[wptr] <= pval[push_ch];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr       <= '0;
      rptr       <= '0;
      Fifo_Level <= '0;
      head_ch    <= 1'b0;
      head_val   <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      rptr       <= rptr_n;
      Fifo_Level <= level_n;
      if (head_ld) begin
        head_ch  <= bypass ? push_ch : mem_ch[rptr_n];
        head_val <= bypass ? pval[push_ch]
                           : mem_val[rptr_n];
      end
    end
  end

  assign Evt.Evt_Valid = Fifo_Level != '0;
  assign Evt.Evt_Ch    = head_ch;
  assign Evt.Evt_Value = head_val;

`ifdef MONITOR_TIMESTAMP_EN
  logic [31:0] ts;
  logic [31:0] ptime    [2];
  logic [31:0] mem_time [FIFO_DEPTH];
  logic [31:0] head_time;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ts        <= '0;
      head_time <= '0;
      for (int c = 0; c < 2; c++)
        ptime[c] <= '0;
    end else begin
      ts <= ts + 32'd1;
      for (int c = 0; c < 2; c++)
        if (hit[c])
          ptime[c] <= ts;
      if (head_ld)
        head_time <= bypass ? ptime[push_ch]
                            : mem_time[rptr_n];
    end
  end

  always_ff @(posedge Clk) begin
    if (push)
      mem_time[wptr] <= ptime[push_ch];
  end

  assign Evt.Evt_Time = head_time;
`else
  assign Evt.Evt_Time = '0;
`endif

endmodule
